// File: rtl/psum_adder_core.sv
// psum_adder_core: 3-stage binarized psum reducer (mask/register, adder tree, accumulate+emit).
// Define PSUM_ADDER_KMASK_EN to zero lanes >= kernel_size^2; otherwise kernel_size is ignored.
module psum_adder_core #(
  parameter int PSUM_IN_WIDTH          = 1536,
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        in_channel,
  input  logic [2:0]                        kernel_size,
  input  logic                              layer_finish,
  input  logic [PSUM_IN_WIDTH-1:0]          psum_in,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] address_in,
  input  logic                              i_valid,
  output logic                              o_valid,
  output logic                              o_data,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] address_out,
  output logic                              o_last
);
  localparam int L  = PSUM_IN_WIDTH / 6;
  localparam int SW = 14;
  localparam int AW = 22;
  logic [PSUM_IN_WIDTH-1:0]          masked_d;
  logic [PSUM_IN_WIDTH-1:0]          psum_q;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] addr1_q, addr2_q;
  logic                              v1_q, v2_q;
  logic signed [SW-1:0]              sum_d, sum_q;
  logic signed [AW-1:0]              acc_d, acc_q;
  logic [7:0]                        cnt_q;
  logic [8:0]                        cnt_d, ic_d;
  logic                              done_d, last_q;
`ifdef PSUM_ADDER_KMASK_EN
  logic [5:0] k_sq;
  assign k_sq = {3'b0, kernel_size} * {3'b0, kernel_size};
  for (genvar i = 0; i < L; i++) begin : g_mask
    assign masked_d[6*i +: 6] = (kernel_size == 3'd0 || i < int'(k_sq)) ? psum_in[6*i +: 6] : 6'd0;
  end
  if (PSUM_IN_WIDTH > 6*L) begin : g_pad
    assign masked_d[PSUM_IN_WIDTH-1:6*L] = '0;
  end
`else
  logic unused_ksize;
  assign unused_ksize = ^kernel_size;
  assign masked_d = psum_in;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      psum_q  <= '0;
      addr1_q <= '0;
    end else begin
      v1_q <= i_valid;
      if (i_valid) begin
        psum_q  <= masked_d;
        addr1_q <= address_in;
      end
    end
  end
  // every lane is sign-extended to the full tree width; 256 x -32 still fits in 14 bits
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < L; i++) sum_d = sum_d + SW'(signed'(psum_q[6*i +: 6]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      sum_q   <= '0;
      addr2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q   <= sum_d;
        addr2_q <= addr1_q;
      end
    end
  end
  assign acc_d  = acc_q + AW'(sum_q);
  assign cnt_d  = {1'b0, cnt_q} + 9'd1;
  assign ic_d   = (in_channel == 8'd0) ? 9'd1 : {1'b0, in_channel};
  assign done_d = v2_q && cnt_d >= ic_d;
  // a layer_finish arriving with an emission is kept for the next pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= 1'b0;
      o_last      <= 1'b0;
      address_out <= '0;
    end else begin
      o_valid <= done_d;
      o_last  <= done_d & last_q;
      if (done_d) begin
        o_data      <= ~acc_d[AW-1];
        address_out <= addr2_q;
        acc_q       <= '0;
        cnt_q       <= '0;
        last_q      <= layer_finish;
      end else begin
        if (v2_q) begin
          acc_q <= acc_d;
          cnt_q <= cnt_d[7:0];
        end
        last_q <= last_q | layer_finish;
      end
    end
  end
endmodule

// File: tb/tb_psum_adder_core.sv
// tb_psum_adder_core: randomized + directed self-checking bench with an integer reference model.
module tb_psum_adder_core;
`ifdef PSUM_ADDER_KMASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  typedef struct {logic d; logic [11:0] a; logic l;} px_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_channel = 8'd1;
  logic [2:0] kernel_size = 3'd0;
  logic layer_finish = 1'b0, i_valid = 1'b0;
  logic [1535:0] psum_in = '0;
  logic [11:0] address_in = '0;
  logic o_valid, o_data, o_last;
  logic [11:0] address_out;
  px_t obs[$];
  int n_tests = 0, n_fail = 0;

  psum_adder_core dut (
    .clk(clk), .rst_n(rst_n), .in_channel(in_channel), .kernel_size(kernel_size),
    .layer_finish(layer_finish), .psum_in(psum_in), .address_in(address_in), .i_valid(i_valid),
    .o_valid(o_valid), .o_data(o_data), .address_out(address_out), .o_last(o_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_valid) obs.push_back('{o_data, address_out, o_last});

  function automatic logic [1535:0] mk2(input int l0, input int l1);
    logic [1535:0] b = '0;
    b[5:0]  = 6'(l0);
    b[11:6] = 6'(l1);
    return b;
  endfunction

  function automatic logic [1535:0] mkall(input int v);
    logic [1535:0] b;
    for (int i = 0; i < 256; i++) b[6*i +: 6] = 6'(v);
    return b;
  endfunction

  // reference: exact integer sum of the lanes that the configuration makes active
  function automatic int beat_sum(input logic [1535:0] b, input logic [2:0] k);
    int n = 256;
    int s = 0;
    if (MASK && k != 3'd0) n = int'(k) * int'(k);
    for (int i = 0; i < n; i++) s += int'($signed(b[6*i +: 6]));
    return s;
  endfunction

  task automatic beat(input logic [1535:0] b, input logic [11:0] a);
    psum_in = b; address_in = a; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    n_tests += 4;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    if (o_data !== 1'b0) begin n_fail++; $display("FAIL reset_o_data got %b want 0", o_data); end
    if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_last got %b want 0", o_last); end
    if (address_out !== 12'h0) begin n_fail++; $display("FAIL reset_addr got %h want 000", address_out); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_spec_vector;
    int l0[8] = '{25, -25, 25, 1, 2, -5, 3, -5};
    int l1[8] = '{-25, -25, 25, -25, 3, -2, -5, 3};
    logic want[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    in_channel = 8'd2; kernel_size = 3'd5;
    idle(4); obs.delete();
    for (int i = 0; i < 8; i++) beat(mk2(l0[i], l1[i]), 12'hAB2);
    idle(4);
    n_tests++;
    if (obs.size() != 4) begin n_fail++; $display("FAIL vec_count got %0d want 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_tests++;
      if (obs[i].d !== want[i] || obs[i].a !== 12'hAB2)
        begin n_fail++; $display("FAIL vec_px%0d got d=%b a=%h want d=%b a=AB2", i, obs[i].d, obs[i].a, want[i]); end
    end
  endtask

  task automatic test_zero_latency;
    int v[2] = '{0, -1};
    logic want[2] = '{1'b1, 1'b0};
    in_channel = 8'd1; kernel_size = 3'd0;
    idle(4);
    for (int j = 0; j < 2; j++) begin
      beat(mk2(v[j], 0), 12'h010 + 12'(j));
      idle(1);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lat%0d_early got o_valid=%b want 0", j, o_valid); end
      idle(1);
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== want[j] || address_out !== 12'h010 + 12'(j))
        begin n_fail++; $display("FAIL lat%0d_out got v=%b d=%b a=%h want v=1 d=%b", j, o_valid, o_data, address_out, want[j]); end
      idle(1);
      n_tests++;
      if (o_valid !== 1'b0 || o_data !== want[j])
        begin n_fail++; $display("FAIL lat%0d_hold got v=%b d=%b want v=0 d=%b", j, o_valid, o_data, want[j]); end
    end
  endtask

  task automatic test_mask;
    logic [2:0] ks[2] = '{3'd1, 3'd0};
    logic [1535:0] b = mk2(1, -20);
    in_channel = 8'd1;
    for (int j = 0; j < 2; j++) begin
      kernel_size = ks[j];
      idle(4); obs.delete();
      beat(b, 12'h0C0);
      idle(4);
      n_tests++;
      if (obs.size() != 1 || obs[0].d !== (beat_sum(b, ks[j]) >= 0))
        begin n_fail++; $display("FAIL mask_k%0d got n=%0d d=%b want n=1 d=%b", ks[j], obs.size(), obs.size() ? obs[0].d : 1'bx, beat_sum(b, ks[j]) >= 0); end
    end
    kernel_size = 3'd0;
  endtask

  task automatic test_extremes;
    int v[2] = '{-32, 31};
    logic want[2] = '{1'b0, 1'b1};
    in_channel = 8'd255; kernel_size = 3'd0;
    for (int j = 0; j < 2; j++) begin
      idle(4); obs.delete();
      for (int i = 0; i < 255; i++) beat(mkall(v[j]), 12'hFFF);
      idle(4);
      n_tests++;
      if (obs.size() != 1 || obs[0].d !== want[j])
        begin n_fail++; $display("FAIL extreme_%0d got n=%0d d=%b want n=1 d=%b", v[j], obs.size(), obs.size() ? obs[0].d : 1'bx, want[j]); end
    end
  endtask

  task automatic test_layer_finish;
    logic want[3] = '{1'b1, 1'b0, 1'b0};
    in_channel = 8'd3; kernel_size = 3'd0;
    idle(4); obs.delete();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++) begin
        layer_finish = (p == 0 && i == 1);
        beat(mk2(p, 1), 12'(p));
        layer_finish = 1'b0;
      end
    idle(4);
    n_tests++;
    if (obs.size() != 3) begin n_fail++; $display("FAIL last_count got %0d want 3", obs.size()); end
    for (int p = 0; p < 3 && p < obs.size(); p++) begin
      n_tests++;
      if (obs[p].l !== want[p] || obs[p].a !== 12'(p))
        begin n_fail++; $display("FAIL last_px%0d got l=%b a=%h want l=%b a=%h", p, obs[p].l, obs[p].a, want[p], 12'(p)); end
    end
  endtask

  task automatic test_reset_mid;
    logic [1535:0] neg = '0;
    for (int i = 0; i < 4; i++) neg[6*i +: 6] = 6'(-30);
    in_channel = 8'd2; kernel_size = 3'd0;
    idle(4); obs.delete();
    beat(neg, 12'h111);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    n_tests++;
    if ({o_valid, o_data, o_last, address_out} !== 15'h0)
      begin n_fail++; $display("FAIL rstmid_outs got v=%b d=%b l=%b a=%h want all 0", o_valid, o_data, o_last, address_out); end
    idle(1);
    rst_n = 1'b1;
    beat(mk2(5, 0), 12'h222);
    beat(mk2(-3, 0), 12'h333);
    idle(4);
    n_tests++;
    if (obs.size() != 1 || obs[0].d !== 1'b1 || obs[0].a !== 12'h333)
      begin n_fail++; $display("FAIL rstmid_px got n=%0d d=%b want n=1 d=1 a=333", obs.size(), obs.size() ? obs[0].d : 1'bx); end
  endtask

  task automatic test_random;
    px_t exp_q[$];
    logic [1535:0] b;
    logic [11:0] a;
    int acc;
    for (int batch = 0; batch < 6; batch++) begin
      in_channel = 8'($urandom_range(0, 4));
      kernel_size = 3'($urandom_range(0, 7));
      idle(4); obs.delete(); exp_q.delete();
      repeat ($urandom_range(2, 5)) begin
        acc = 0;
        for (int i = 0; i < (in_channel == 0 ? 1 : int'(in_channel)); i++) begin
          for (int l = 0; l < 256; l++) b[6*l +: 6] = 6'($urandom);
          a = 12'($urandom);
          acc += beat_sum(b, kernel_size);
          beat(b, a);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        exp_q.push_back('{acc >= 0, a, 1'b0});
      end
      idle(4);
      n_tests++;
      if (obs.size() != exp_q.size())
        begin n_fail++; $display("FAIL rnd%0d_count got %0d want %0d", batch, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        n_tests++;
        if (obs[i] != exp_q[i])
          begin n_fail++; $display("FAIL rnd%0d_px%0d got d=%b a=%h l=%b want d=%b a=%h l=0", batch, i, obs[i].d, obs[i].a, obs[i].l, exp_q[i].d, exp_q[i].a); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_spec_vector;
    test_zero_latency;
    test_mask;
    test_extremes;
    test_layer_finish;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
